hazard_forward_ctrl: RTL
========================

Name: hazard_forward_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage LD/SD/ALU RISC-V pipeline (IF, ID, EX, MEM, WB).
- Keeps its own shadow copy of the IDEX, EXMEM and MEMWB instruction registers, fed from the IFID instruction word.
- Drives the pipeline's PC/IFID hold and bubble injection on a load-use hazard.
- Drives the EX-stage ALU-input mux selects and the ID-stage WB bypass selects.
- Counts stall cycles for performance reporting.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.
- NOP_INSTR, 32'h0000_0013, instruction word injected as a bubble and loaded at reset.

Ports:
- clock  in  1  pipeline clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- advance  in  1  pipeline clock-enable; shadow state moves only when 1.
- ifid_ir  in  32  current IFIDIR contents.
- stall  out  1  combinational; 1 = hold PC and IFIDIR and load NOP_INSTR into IDEXIR this edge.
- fwd_a  out  2  combinational EX select for Ain: 00 IDEXA, 10 EXMEMALUOut, 01 MEMWBValue.
- fwd_b  out  2  same encoding for Bin and for the store data passed to EXMEMB.
- byp_id_a  out  1  combinational; ID latches MEMWBValue instead of Regs[rs1].
- byp_id_b  out  1  same for rs2.
- stall_cnt  out  STALL_CNT_W  registered count of stall cycles.

Behaviour:
- Field decode: op = [6:0], rd = [11:7], rs1 = [19:15], rs2 = [24:20].
- LD = 0000011, SD = 0100011, BEQ = 1100011, ALUop = 0010011.
- Writers: LD or ALUop with rd != 0. Any other opcode, or rd = 0, never writes.
- rs1 readers: LD, SD, ALUop, BEQ.
- rs2 readers: SD, ALUop, BEQ. ALUop reads rs2 because the datapath adds Ain+Bin.
- Unknown opcodes read nothing and write nothing.
- Shadow regs sh_idex, sh_exmem, sh_memwb: on posedge with reset_n = 0, all three load NOP_INSTR and stall_cnt loads 0; this takes priority over advance.
- Posedge, reset_n = 1, advance = 1:
  - sh_memwb <= sh_exmem; sh_exmem <= sh_idex.
  - sh_idex <= stall ? NOP_INSTR : ifid_ir.
  - if stall, stall_cnt increments, saturating at all-ones.
- Posedge, reset_n = 1, advance = 0: all state holds, including stall_cnt. Combinational outputs remain valid.
- Load-use stall: stall = 1 when sh_idex is LD with rd != 0, and rd matches ifid_ir rs1 (rs1 reader) or rs2 (rs2 reader).
  - The stall lasts exactly 1 cycle. The next cycle the LD is in sh_exmem, sh_idex is the bubble, and stall falls.
- fwd_a (rs1 of sh_idex; 00 if sh_idex is not an rs1 reader):
  - 10 if sh_exmem is ALUop, a writer, and its rd equals rs1.
  - else 01 if sh_memwb is a writer and its rd equals rs1.
  - else 00.
  - A LD in sh_exmem is never forwarded; the stall guarantees this case cannot arise.
  - Youngest producer wins when both match.
- fwd_b: identical rule applied to rs2, gated by rs2-reader.
- byp_id_a / byp_id_b: 1 when sh_memwb is a writer and its rd equals ifid_ir rs1 / rs2, gated by reader class. This covers the WB write and ID read landing on the same edge.
- No output ever asserts for register x0.
- Bubble and reset instruction is NOP_INSTR (ALUop, rd = 0), so it produces no forwards.
- Reset mid-stall: stall is purely combinational on shadow state, so it deasserts the cycle after the reset edge.
- Latency: stall, fwd_* and byp_* are 0-cycle (same cycle as the inputs); stall_cnt updates 1 edge after a stall cycle.

Test Plan:
- Reset: hold reset_n = 0 for 2 edges with ifid_ir = 0x00403083 (ld x1,4(x0)) -> stall = 0, fwd_a = fwd_b = 00, byp_id_a = byp_id_b = 0, stall_cnt = 0.
- Load-use: feed 0x00403083 then 0x00108113 (add x2,x1,x1), advance = 1.
  - stall = 1 for exactly one cycle, and a NOP enters sh_idex.
  - The cycle the add reaches EX: fwd_a = fwd_b = 01.
  - stall_cnt = 1.
- EX forward: feed 0x00108113 then 0x00210193 (add x3,x2,x2) -> stall = 0, fwd_a = fwd_b = 10 with the second add in EX.
- Store data: feed ld x1, two NOPs, then 0x00103423 (sd x1,8(x0)) -> byp_id_b = 1 with the sd in ID; no stall; fwd_b = 00 in EX.
- Advance low: create a load-use, drop advance for 3 cycles -> stall holds 1, shadow unchanged, stall_cnt unchanged; on raising advance, stall_cnt increments once.
- x0 / saturation: ld x0 followed by add x2,x0,x0 -> no stall, no forward. Force STALL_CNT_W = 2 and run 5 load-use pairs -> stall_cnt = 3.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// hazard_forward_ctrl: load-use stall, EX-stage forwarding and ID-stage WB bypass
// control for a 5-stage LD/SD/ALU pipeline, tracked through shadow instruction registers.
module hazard_forward_ctrl #(
  parameter int          STALL_CNT_W = 16,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   advance,
  input  logic [31:0]            ifid_ir,
  output logic                   stall,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic                   byp_id_a,
  output logic                   byp_id_b,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_ALU = 7'b0010011;

  function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] rd);
    return ((op == OP_LD) || (op == OP_ALU)) && (rd != 5'd0);
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return (op == OP_LD) || (op == OP_SD) || (op == OP_ALU) || (op == OP_BEQ);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return (op == OP_SD) || (op == OP_ALU) || (op == OP_BEQ);
  endfunction

  logic [31:0] sh_idex;
  logic [31:0] sh_exmem;
  logic [31:0] sh_memwb;

  logic [6:0] id_op, idex_op, exmem_op, memwb_op;
  logic [4:0] id_rs1, id_rs2, idex_rd, idex_rs1, idex_rs2, exmem_rd, memwb_rd;
  logic       exmem_alu_wr, memwb_wr;
  logic       unused_bits;

  assign id_op    = ifid_ir[6:0];
  assign id_rs1   = ifid_ir[19:15];
  assign id_rs2   = ifid_ir[24:20];
  assign idex_op  = sh_idex[6:0];
  assign idex_rd  = sh_idex[11:7];
  assign idex_rs1 = sh_idex[19:15];
  assign idex_rs2 = sh_idex[24:20];
  assign exmem_op = sh_exmem[6:0];
  assign exmem_rd = sh_exmem[11:7];
  assign memwb_op = sh_memwb[6:0];
  assign memwb_rd = sh_memwb[11:7];
  assign unused_bits = ^sh_memwb[31:12];

  // A load in EX/MEM has no result yet, so only ALU producers forward from there.
  assign exmem_alu_wr = (exmem_op == OP_ALU) && writes_rd(exmem_op, exmem_rd);
  assign memwb_wr     = writes_rd(memwb_op, memwb_rd);

  assign stall = (idex_op == OP_LD) && (idex_rd != 5'd0) &&
                 ((reads_rs1(id_op) && (id_rs1 == idex_rd)) ||
                  (reads_rs2(id_op) && (id_rs2 == idex_rd)));

  always_comb begin
    fwd_a = 2'b00;
    if (reads_rs1(idex_op)) begin
      if (exmem_alu_wr && (exmem_rd == idex_rs1))
        fwd_a = 2'b10;
      else if (memwb_wr && (memwb_rd == idex_rs1))
        fwd_a = 2'b01;
    end
  end

  always_comb begin
    fwd_b = 2'b00;
    if (reads_rs2(idex_op)) begin
      if (exmem_alu_wr && (exmem_rd == idex_rs2))
        fwd_b = 2'b10;
      else if (memwb_wr && (memwb_rd == idex_rs2))
        fwd_b = 2'b01;
    end
  end

  assign byp_id_a = memwb_wr && reads_rs1(id_op) && (memwb_rd == id_rs1);
  assign byp_id_b = memwb_wr && reads_rs2(id_op) && (memwb_rd == id_rs2);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sh_idex   <= NOP_INSTR;
      sh_exmem  <= NOP_INSTR;
      sh_memwb  <= NOP_INSTR;
      stall_cnt <= '0;
    end else if (advance) begin
      sh_memwb <= sh_exmem;
      sh_exmem <= sh_idex;
      sh_idex  <= stall ? NOP_INSTR : ifid_ir;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
